// File: rtl/control_output_queue_if.sv
// Host-bound descriptor queue bus.
//   Write side : iv_fifo_wdata[13:0] {hit, inport[3:0], bufid[8:0]}, i_fifo_wr
//   Issue side : ov_pkt_bufid, ov_pkt_inport, o_mac_entry_hit, o_pkt_bufid_wr,
//                i_pkt_bufid_ack
//   Status     : ov_queue_usedw[AW:0], o_queue_full, o_queue_empty
//   Optional   : ov_drop_cnt[15:0] when CTRL_QUEUE_DROP_CNT_EN is defined
// Modport slave is the queue itself. Modport master is the surrounding logic,
// which drives the write strobe and the ack.
interface control_output_queue_if #(
    parameter int AW = 4
);
    logic [13:0]   iv_fifo_wdata;
    logic          i_fifo_wr;
    logic [8:0]    ov_pkt_bufid;
    logic [3:0]    ov_pkt_inport;
    logic          o_mac_entry_hit;
    logic          o_pkt_bufid_wr;
    logic          i_pkt_bufid_ack;
    logic [AW:0]   ov_queue_usedw;
    logic          o_queue_full;
    logic          o_queue_empty;
`ifdef CTRL_QUEUE_DROP_CNT_EN
    logic [15:0]   ov_drop_cnt;

    modport slave (
        input  iv_fifo_wdata, i_fifo_wr, i_pkt_bufid_ack,
        output ov_pkt_bufid, ov_pkt_inport, o_mac_entry_hit, o_pkt_bufid_wr,
               ov_queue_usedw, o_queue_full, o_queue_empty, ov_drop_cnt
    );
    modport master (
        output iv_fifo_wdata, i_fifo_wr, i_pkt_bufid_ack,
        input  ov_pkt_bufid, ov_pkt_inport, o_mac_entry_hit, o_pkt_bufid_wr,
               ov_queue_usedw, o_queue_full, o_queue_empty, ov_drop_cnt
    );
`else
    modport slave (
        input  iv_fifo_wdata, i_fifo_wr, i_pkt_bufid_ack,
        output ov_pkt_bufid, ov_pkt_inport, o_mac_entry_hit, o_pkt_bufid_wr,
               ov_queue_usedw, o_queue_full, o_queue_empty
    );
    modport master (
        output iv_fifo_wdata, i_fifo_wr, i_pkt_bufid_ack,
        input  ov_pkt_bufid, ov_pkt_inport, o_mac_entry_hit, o_pkt_bufid_wr,
               ov_queue_usedw, o_queue_full, o_queue_empty
    );
`endif
endinterface

// File: rtl/control_output_queue.sv
// control_output_queue
//   Buffers 14-bit control entries {mac_hit, inport[3:0], bufid[8:0]} from the
//   input-queue stage and issues them in arrival order, one at a time, to the
//   host-port transmit logic over a valid/ack handshake.
// Ports
//   i_clk    : system clock
//   i_rst_n  : asynchronous reset, active low
//   bus      : control_output_queue_if.slave (write port, issue port, status)
// Parameters
//   DEPTH    : entries, power of two 4..256
//   AW       : log2(DEPTH)
// Build option
//   CTRL_QUEUE_DROP_CNT_EN : adds a saturating 16-bit counter of writes that
//                            were dropped because the queue was full.
module control_output_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    control_output_queue_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_GAP      = 2'd2
    } state_t;

    state_t        r_state;
    logic [13:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          r_full;
    logic          r_empty;
    logic          w_wr_ok;
    logic          w_pop;
    logic [8:0]    r_bufid;
    logic [3:0]    r_inport;
    logic          r_hit;
    logic          r_wr;

    // Full decision uses the pre-edge count: a write that arrives while full is
    // dropped even if the FSM frees a slot on the same edge.
    assign w_wr_ok = bus.i_fifo_wr & ~r_full;
    // Pop only happens when the FSM loads a new descriptor; the ack itself
    // does not touch the stored count.
    assign w_pop   = (r_state == S_IDLE) & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_wr_ok && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    // Storage array is not reset; pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok)
            r_mem[r_wr_ptr] <= bus.iv_fifo_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Issue FSM: IDLE loads the head entry, WAIT_ACK holds it, GAP inserts
    // one dead cycle so back-to-back descriptors are 3 cycles apart.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= '0;
            r_wr     <= 1'b0;
            r_bufid  <= '0;
            r_inport <= '0;
            r_hit    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_hit, r_inport, r_bufid} <= r_mem[r_rd_ptr];
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_wr     <= 1'b1;
                        r_state  <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.i_pkt_bufid_ack) begin
                        r_wr     <= 1'b0;
                        r_bufid  <= '0;
                        r_inport <= '0;
                        r_hit    <= 1'b0;
                        r_state  <= S_GAP;
                    end
                end
                S_GAP:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CTRL_QUEUE_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_drop_cnt <= '0;
        else if (bus.i_fifo_wr && r_full && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign bus.ov_drop_cnt = r_drop_cnt;
`endif

    assign bus.ov_pkt_bufid    = r_bufid;
    assign bus.ov_pkt_inport   = r_inport;
    assign bus.o_mac_entry_hit = r_hit;
    assign bus.o_pkt_bufid_wr  = r_wr;
    assign bus.ov_queue_usedw  = r_count;
    assign bus.o_queue_full    = r_full;
    assign bus.o_queue_empty   = r_empty;
endmodule

// File: tb/tb_control_output_queue.sv
// Bench for control_output_queue: fixed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference.
module tb_control_output_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_output_queue_if #(.AW(AW)) bus ();

    control_output_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: stored entries as a queue, plus the descriptor on offer.
    logic [13:0] m_q[$];
    bit          m_busy;
    bit          m_gap;
    logic [13:0] m_desc;

    logic [8:0]  dut_log[$];
    int          rise_cyc[$];
    bit          prev_wr;

    typedef struct {
        logic        wr;
        logic [13:0] d;
        logic        ack;
        logic [21:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [21:0] dut_vec();
        return {bus.o_pkt_bufid_wr, bus.ov_pkt_bufid, bus.ov_pkt_inport, bus.o_mac_entry_hit,
                bus.ov_queue_usedw, bus.o_queue_full, bus.o_queue_empty};
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [13:0] d;
        d = m_busy ? m_desc : 14'd0;
        return {m_busy, d[8:0], d[12:9], d[13], 5'(m_q.size()),
                (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    // One clock edge of the reference, using the inputs present before the edge.
    task automatic model_edge();
        bit full, pop, was_busy, was_gap;
        full     = (m_q.size() == DEPTH);
        was_busy = m_busy;
        was_gap  = m_gap;
        pop      = !was_busy && !was_gap && (m_q.size() != 0);
        if (pop) begin
            m_desc = m_q.pop_front();
            m_busy = 1'b1;
        end else if (was_busy && bus.i_pkt_bufid_ack) begin
            m_busy = 1'b0;
            m_gap  = 1'b1;
        end else if (was_gap) begin
            m_gap = 1'b0;
        end
        if (bus.i_fifo_wr && !full)
            m_q.push_back(bus.iv_fifo_wdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("model", 32'(dut_vec()), 32'(exp_vec()));
        if (bus.o_pkt_bufid_wr && !prev_wr) begin
            dut_log.push_back(bus.ov_pkt_bufid);
            rise_cyc.push_back(cyc);
        end
        prev_wr = bus.o_pkt_bufid_wr;
    endtask

    task automatic drive(input logic wr, input logic [13:0] d, input logic ack);
        bus.i_fifo_wr       = wr;
        bus.iv_fifo_wdata   = d;
        bus.i_pkt_bufid_ack = ack;
    endtask

    task automatic do_reset();
        drive(1'b0, 14'd0, 1'b0);
        rst_n = 1'b0;
        m_q.delete();
        m_busy = 1'b0;
        m_gap  = 1'b0;
        m_desc = '0;
        dut_log.delete();
        rise_cyc.delete();
        prev_wr = 1'b0;
        #12;
        chk("reset_state", 32'(dut_vec()), 32'({1'b0, 9'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vt[8];
    int   sent;
    logic [13:0] wq[$];
    bit   seen;

    initial begin
        // Single entry issue/ack, then ack ignored outside the handshake.
        vt[0] = '{1'b1, 14'h2A05, 1'b0, {1'b0, 9'h000, 4'h0, 1'b0, 5'd1, 1'b0, 1'b0}};
        vt[1] = '{1'b0, 14'h0000, 1'b0, {1'b1, 9'h005, 4'h5, 1'b1, 5'd0, 1'b0, 1'b1}};
        vt[2] = '{1'b0, 14'h0000, 1'b0, {1'b1, 9'h005, 4'h5, 1'b1, 5'd0, 1'b0, 1'b1}};
        vt[3] = '{1'b0, 14'h0000, 1'b1, {1'b0, 9'h000, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1}};
        vt[4] = '{1'b0, 14'h0000, 1'b0, {1'b0, 9'h000, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1}};
        vt[5] = '{1'b1, 14'h1FFF, 1'b1, {1'b0, 9'h000, 4'h0, 1'b0, 5'd1, 1'b0, 1'b0}};
        vt[6] = '{1'b0, 14'h0000, 1'b0, {1'b1, 9'h1FF, 4'hF, 1'b0, 5'd0, 1'b0, 1'b1}};
        vt[7] = '{1'b0, 14'h0000, 1'b1, {1'b0, 9'h000, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1}};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].wr, vt[i].d, vt[i].ack);
            cycle();
            chk($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vt[i].exp));
        end

        // Burst of 18 writes without ack: 17 fit (one is on offer), 18th dropped.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, {1'b0, 4'h3, 9'(i)}, 1'b0);
            cycle();
            if (i == 15) begin
                chk("burst_usedw15", 32'(bus.ov_queue_usedw), 32'd15);
                chk("burst_notfull", 32'(bus.o_queue_full), 32'd0);
            end
            if (i == 16) chk("burst_full", 32'(bus.o_queue_full), 32'd1);
        end
        chk("burst_drop_usedw", 32'(bus.ov_queue_usedw), 32'd16);
        drive(1'b0, 14'd0, 1'b1);
        for (int c = 0; c < 70; c++) cycle();
        chk("burst_count", 32'(dut_log.size()), 32'd17);
        for (int i = 0; i < dut_log.size() && i < 17; i++)
            chk($sformatf("burst_order%0d", i), 32'(dut_log[i]), 32'(i));

        // Full queue: write on the same edge as a pop is dropped.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, {1'b1, 4'h7, 9'(200 + i)}, 1'b0);
            cycle();
        end
        drive(1'b0, 14'd0, 1'b1);  cycle();
        drive(1'b0, 14'd0, 1'b0);  cycle();
        chk("full_before", 32'({bus.o_queue_full, bus.ov_queue_usedw}), 32'({1'b1, 5'd16}));
        drive(1'b1, {1'b0, 4'h1, 9'h1AA}, 1'b0);
        cycle();
        chk("full_pop_drop", 32'({bus.o_queue_full, bus.ov_queue_usedw}), 32'({1'b0, 5'd15}));
        drive(1'b0, 14'd0, 1'b1);
        for (int c = 0; c < 70; c++) cycle();
        chk("full_drain_count", 32'(dut_log.size()), 32'd17);
        seen = 1'b0;
        foreach (dut_log[i]) if (dut_log[i] == 9'h1AA) seen = 1'b1;
        chk("full_dropped_absent", 32'(seen), 32'd0);

        // Stream of 40 with ack tied high: order across wrap and 3-cycle spacing.
        do_reset();
        sent = 0;
        wq.delete();
        for (int c = 0; c < 400 && dut_log.size() < 40; c++) begin
            if (sent < 40 && m_q.size() < DEPTH) begin
                drive(1'b1, {1'(sent % 2), 4'(sent % 16), 9'(100 + sent)}, 1'b1);
                wq.push_back({1'(sent % 2), 4'(sent % 16), 9'(100 + sent)});
                sent++;
            end else begin
                drive(1'b0, 14'd0, 1'b1);
            end
            cycle();
        end
        chk("stream_count", 32'(dut_log.size()), 32'd40);
        for (int i = 0; i < dut_log.size() && i < wq.size(); i++)
            chk($sformatf("stream_order%0d", i), 32'(dut_log[i]), 32'(wq[i][8:0]));
        for (int i = 1; i < rise_cyc.size(); i++)
            chk($sformatf("stream_gap%0d", i), 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd3);

        // Asynchronous reset while a descriptor is on offer.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, {1'b0, 4'h2, 9'(300 + i)}, 1'b0);
            cycle();
        end
        chk("mid_usedw", 32'({bus.o_pkt_bufid_wr, bus.ov_queue_usedw}), 32'({1'b1, 5'd5}));
        drive(1'b0, 14'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_wr_drop", 32'(bus.o_pkt_bufid_wr), 32'd0);
        do_reset();
        for (int c = 0; c < 4; c++) cycle();
        chk("post_reset", 32'({bus.o_queue_empty, bus.ov_queue_usedw, 8'(dut_log.size())}),
            32'({1'b1, 5'd0, 8'd0}));

        // Random traffic against the reference.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 9) < 6), 14'($urandom), 1'($urandom_range(0, 1)));
            cycle();
        end

`ifdef CTRL_QUEUE_DROP_CNT_EN
        do_reset();
        chk("drop_reset", 32'(bus.ov_drop_cnt), 32'd0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, {1'b0, 4'h0, 9'(i)}, 1'b0);
            cycle();
        end
        for (int i = 0; i < 20; i++) cycle();
        chk("drop_cnt20", 32'(bus.ov_drop_cnt), 32'd20);
        for (int i = 0; i < 65520; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("drop_saturate", 32'(bus.ov_drop_cnt), 32'h0000FFFF);
        drive(1'b0, 14'd0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
